// File: rtl/fir_tdm_sequencer_if.sv
// Sample, result and coefficient-write signals of the time-multiplexed FIR.
// slave is the filter side, master is the source/sink side.
interface fir_tdm_sequencer_if #(
    parameter int ORDER      = 31,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 16
);
    localparam int N  = ORDER + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic                         s_valid_i;
    logic                         s_ready_o;
    logic signed [DATA_WIDTH-1:0] s_data_i;
    logic                         coef_we_i;
    logic [KW-1:0]                coef_addr_i;
    logic signed [COEF_WIDTH-1:0] coef_data_i;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic signed [DATA_WIDTH-1:0] m_data_o;

    modport slave (
        input  s_valid_i, s_data_i, coef_we_i, coef_addr_i, coef_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o
    );

    modport master (
        output s_valid_i, s_data_i, coef_we_i, coef_addr_i, coef_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one MAC stepped over all taps per sample, circular
// delay line, run-time loadable coefficients, scaled/saturated output.
module fir_tdm_sequencer #(
    parameter int ORDER      = 31,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fir_tdm_sequencer_if.slave    bus,
    output logic                  busy_o
);
    localparam int N  = ORDER + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DATA_WIDTH;
    localparam int CW = COEF_WIDTH;
    localparam int AW = DW + CW + KW;

    localparam logic [KW-1:0]        LAST = KW'(ORDER);
    localparam logic [KW-1:0]        NM1  = KW'(N - 1);
    localparam logic [KW:0]          NW   = (KW + 1)'(N);
    localparam logic signed [AW-1:0] YMAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                state_q;
    logic                  busy_q, s_ready_q, m_valid_q;
    logic signed [DW-1:0]  m_data_q;
    logic [KW-1:0]         wptr_q, rd_q, k_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [DW-1:0]  x_q [N];
    logic signed [CW-1:0]  c_q [N];

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    prod_ext, acc_d;

    assign prod     = c_q[k_q] * x_q[rd_q];
    assign prod_ext = prod;
    assign acc_d    = acc_q + prod_ext;

    // Arithmetic shift floors toward -inf; then clamp to the output range.
    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] sh;
        sh = a >>> CW;
        if (sh > YMAX)      sat = YMAX[DW-1:0];
        else if (sh < YMIN) sat = YMIN[DW-1:0];
        else                sat = sh[DW-1:0];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            wptr_q    <= '0;
            rd_q      <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            for (int i = 0; i < N; i++) x_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (bus.s_valid_i && s_ready_q) begin
                        x_q[wptr_q] <= bus.s_data_i;
                        rd_q        <= wptr_q;
                        k_q         <= '0;
                        acc_q       <= '0;
                        state_q     <= MAC;
                        busy_q      <= 1'b1;
                        s_ready_q   <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + KW'(1);
                    rd_q  <= (rd_q == '0) ? NM1 : rd_q - KW'(1);
                    if (k_q == LAST) begin
                        state_q   <= OUT;
                        wptr_q    <= (wptr_q == NM1) ? '0 : wptr_q + KW'(1);
                        m_data_q  <= sat(acc_d);
                        m_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.m_ready_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes are blocked during MAC so one result never mixes coefficient sets.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) c_q[i] <= '0;
        end else if (bus.coef_we_i && state_q != MAC && {1'b0, bus.coef_addr_i} < NW) begin
            c_q[bus.coef_addr_i] <= bus.coef_data_i;
        end
    end

    assign bus.s_ready_o = s_ready_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = m_data_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Randomized bench for fir_tdm_sequencer against a direct convolution model
// (sample history, most recent first, dotted with the coefficient table).
module tb_fir_tdm_sequencer;
    localparam int ORDER = 31;
    localparam int N     = ORDER + 1;
    localparam int DW    = 8;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    fir_tdm_sequencer_if #(.ORDER(ORDER), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus();

    fir_tdm_sequencer #(.ORDER(ORDER), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int hist [N];
    int coef [N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i] = 0;
            coef[i] = 0;
        end
    endfunction

    // y[n] = clamp(floor(sum_k c[k]*x[n-k] / 2^CW))
    function automatic int model_push(input int d);
        longint s;
        longint y;
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(coef[i]) * longint'(hist[i]);
        y = s >>> CW;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return int'(y);
    endfunction

    task automatic write_coef(input int addr, input int val);
        bus.coef_we_i   = 1'b1;
        bus.coef_addr_i = 5'(addr);
        bus.coef_data_i = 16'(val);
        @(posedge clk); #1;
        bus.coef_we_i = 1'b0;
        coef[addr] = val;
    endtask

    task automatic set_all_coefs(input int val);
        for (int i = 0; i < N; i++) write_coef(i, val);
    endtask

    task automatic accept_sample(input int d, output bit ok);
        bit rdy;
        ok = 1'b0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'(d);
        for (int i = 0; i < 100; i++) begin
            rdy = bus.s_ready_o;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic read_out(output int y);
        y = int'(bus.m_data_o);
        bus.m_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.m_ready_i = 1'b0;
    endtask

    task automatic send(input int d, output int y, output int lat);
        bit ok;
        accept_sample(d, ok);
        lat = -1;
        if (ok) wait_valid(lat);
        read_out(y);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid_o); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++;
        if (bus.m_data_o !== 8'sd0) begin n_fail++; $display("FAIL reset_m_data got %0d exp 0", bus.m_data_o); end
        n_checks++;
        if (bus.s_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b exp 0", bus.s_ready_o); end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready_after got %b exp 1", bus.s_ready_o); end
    endtask

    task automatic test_impulse();
        int y, lat, e;
        do_reset();
        set_all_coefs(16384);
        for (int i = 0; i < 41; i++) begin
            send((i == 0) ? 100 : 0, y, lat);
            e = model_push((i == 0) ? 100 : 0);
            n_checks++;
            if (y !== e || y !== ((i < N) ? 25 : 0)) begin
                n_fail++; $display("FAIL impulse[%0d] got %0d exp %0d", i, y, e);
            end
            n_checks++;
            if (lat !== N) begin n_fail++; $display("FAIL impulse_latency[%0d] got %0d exp %0d", i, lat, N); end
        end
    endtask

    task automatic test_step_saturation();
        int y, lat, e;
        do_reset();
        set_all_coefs(16384);
        for (int i = 0; i < 10; i++) begin
            send(100, y, lat);
            e = model_push(100);
            n_checks++;
            if (y !== e) begin n_fail++; $display("FAIL step_pos[%0d] got %0d exp %0d", i, y, e); end
        end
        do_reset();
        set_all_coefs(16384);
        for (int i = 0; i < 10; i++) begin
            send(-128, y, lat);
            e = model_push(-128);
            n_checks++;
            if (y !== e) begin n_fail++; $display("FAIL step_neg[%0d] got %0d exp %0d", i, y, e); end
        end
    endtask

    task automatic test_wrap_random();
        int y, lat, e, d;
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, k * 256);
        for (int i = 0; i < 70; i++) begin
            d = int'($signed(8'($urandom)));
            send(d, y, lat);
            e = model_push(d);
            n_checks++;
            if (y !== e) begin n_fail++; $display("FAIL wrap[%0d] in %0d got %0d exp %0d", i, d, y, e); end
        end
    endtask

    task automatic test_backpressure();
        int y, lat, e, d, held;
        bit ok;
        d = int'($signed(8'($urandom)));
        accept_sample(d, ok);
        e = model_push(d);
        wait_valid(lat);
        held = int'(bus.m_data_o);
        n_checks++;
        if (held !== e || lat !== N) begin
            n_fail++; $display("FAIL bp_first got %0d lat %0d exp %0d lat %0d", held, lat, e, N);
        end
        for (int i = 0; i < 20; i++) begin
            bus.s_valid_i = i[0];
            bus.s_data_i  = 8'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (bus.m_valid_o !== 1'b1 || int'(bus.m_data_o) !== held || bus.s_ready_o !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0d rdy=%b busy=%b exp v=1 d=%0d rdy=0 busy=1",
                         i, bus.m_valid_o, bus.m_data_o, bus.s_ready_o, busy, held);
            end
        end
        bus.s_valid_i = 1'b0;
        read_out(y);
        n_checks++;
        if (bus.s_ready_o !== 1'b1 || bus.m_valid_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got rdy=%b v=%b busy=%b exp 1 0 0", bus.s_ready_o, bus.m_valid_o, busy);
        end
        d = int'($signed(8'($urandom)));
        send(d, y, lat);
        e = model_push(d);
        n_checks++;
        if (y !== e) begin n_fail++; $display("FAIL bp_next got %0d exp %0d", y, e); end
    endtask

    task automatic test_coef_write_mac();
        int y, lat, e;
        bit ok;
        do_reset();
        accept_sample(50, ok);
        e = model_push(50);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        bus.coef_we_i   = 1'b1;
        bus.coef_addr_i = '0;
        bus.coef_data_i = 16'sd32767;
        @(posedge clk); #1;
        bus.coef_we_i = 1'b0;
        wait_valid(lat);
        read_out(y);
        n_checks++;
        if (y !== e || lat < 0) begin n_fail++; $display("FAIL coef_mac_cur got %0d exp %0d", y, e); end
        send(20, y, lat);
        e = model_push(20);
        n_checks++;
        if (y !== e) begin n_fail++; $display("FAIL coef_mac_next got %0d exp %0d", y, e); end
        write_coef(0, 32767);
        send(64, y, lat);
        e = model_push(64);
        n_checks++;
        if (y !== e || y !== 31) begin n_fail++; $display("FAIL coef_idle got %0d exp %0d", y, e); end
    endtask

    task automatic test_reset_mid_mac();
        int y, lat, e;
        bit ok;
        do_reset();
        set_all_coefs(16384);
        for (int i = 0; i < 4; i++) send(77, y, lat);
        accept_sample(77, ok);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.m_valid_o !== 1'b0 || busy !== 1'b0 || bus.m_data_o !== 8'sd0) begin
            n_fail++; $display("FAIL rst_mid got v=%b busy=%b d=%0d exp 0 0 0", bus.m_valid_o, busy, bus.m_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b exp 1", bus.s_ready_o); end
        send(100, y, lat);
        e = model_push(100);
        n_checks++;
        if (y !== e || y !== 0) begin n_fail++; $display("FAIL rst_mid_coef_clear got %0d exp %0d", y, e); end
        set_all_coefs(16384);
        send(0, y, lat);
        e = model_push(0);
        n_checks++;
        if (y !== e) begin n_fail++; $display("FAIL rst_mid_buf_clear got %0d exp %0d", y, e); end
    endtask

    initial begin
        bus.s_valid_i   = 1'b0;
        bus.s_data_i    = '0;
        bus.coef_we_i   = 1'b0;
        bus.coef_addr_i = '0;
        bus.coef_data_i = '0;
        bus.m_ready_i   = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_impulse();
        test_step_saturation();
        test_wrap_random();
        test_backpressure();
        test_coef_write_mac();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
